axis_fifo_ctrl: RTL and testbench

Single-clock AXI4-Stream FIFO controller that sits directly in front of the `memory` storage array. It accepts a slave AXIS stream, drives the memory write port (enable, address, data) and read address, and presents the memory's combinational read data as a first-word-fall-through master AXIS stream. It owns all pointer, occupancy and full/empty logic; the memory holds only data.

---
 rtl/axis_fifo_ctrl.sv | 72 +++++++
 tb/tb_axis_fifo_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_ctrl.sv
// AXI4-Stream FIFO controller driving an external storage array with a
// combinational read port; presents a first-word-fall-through output stream.
module axis_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int ACTUAL_DEPTH = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    output logic [WIDTH-1:0]      m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
    output logic [WIDTH-1:0]      mem_wr_data_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [WIDTH-1:0]      mem_rd_data_i,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(ACTUAL_DEPTH);
    localparam logic [ADDR_WIDTH:0] ZERO_COUNT = '0;

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] count_next;
    logic                push;
    logic                pop;

    // A beat transfers on any edge where valid and ready are both high; valid
    // never waits on ready, and ready is a registered function of occupancy only.
    assign push = s_axis_tvalid_i & s_axis_tready_o;
    assign pop  = m_axis_tvalid_o & m_axis_tready_i;

    assign mem_wr_en_o    = push;
    assign mem_wr_addr_o  = wr_ptr[ADDR_WIDTH-1:0];
    assign mem_wr_data_o  = s_axis_tdata_i;
    assign mem_rd_addr_o  = rd_ptr[ADDR_WIDTH-1:0];
    assign m_axis_tdata_o = mem_rd_data_i;

    always_comb begin
        count_next = count_o + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
    end

    // All flags derive from count_next so they are valid on the same edge as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count_o         <= '0;
            full_o          <= 1'b0;
            empty_o         <= 1'b1;
            s_axis_tready_o <= 1'b0;
            m_axis_tvalid_o <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr + {{ADDR_WIDTH{1'b0}}, push};
            rd_ptr          <= rd_ptr + {{ADDR_WIDTH{1'b0}}, pop};
            count_o         <= count_next;
            full_o          <= (count_next == FULL_COUNT);
            s_axis_tready_o <= (count_next != FULL_COUNT);
            empty_o         <= (count_next == ZERO_COUNT);
            m_axis_tvalid_o <= (count_next != ZERO_COUNT);
        end
    end

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Bench for axis_fifo_ctrl: behavioural storage arrays, a queue reference model
// and directed plus random stream traffic on DEPTH=8 and DEPTH=5 instances.
module tb_axis_fifo_ctrl;

    localparam int DEPTH_A = 8;

    logic       clk = 1'b0;
    logic       rst;
    int         total_cnt = 0;
    int         pass_cnt  = 0;
    int         fail_cnt  = 0;

    always #5 clk = ~clk;

    // DEPTH=8 instance
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b0;
    logic       mem_wr_en;
    logic [2:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic [2:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic [7:0] mem_a [0:7];

    axis_fifo_ctrl #(.WIDTH(8), .DEPTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
        .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
        .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
        .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
        .count_o(count), .full_o(full), .empty_o(empty)
    );

    always @(posedge clk) if (mem_wr_en) mem_a[mem_wr_addr] <= mem_wr_data;
    assign mem_rd_data = mem_a[mem_rd_addr];

    // DEPTH=5 instance (rounds up to 8 entries)
    logic [7:0] b_tdata = '0;
    logic       b_tvalid = 1'b0;
    logic       b_tready;
    logic [7:0] b_mdata;
    logic       b_mvalid;
    logic       b_mready = 1'b0;
    logic       b_wr_en;
    logic [2:0] b_wr_addr;
    logic [7:0] b_wr_data;
    logic [2:0] b_rd_addr;
    logic [7:0] b_rd_data;
    logic [3:0] b_count;
    logic       b_full;
    logic       b_empty;
    logic [7:0] mem_b [0:7];

    axis_fifo_ctrl #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst),
        .s_axis_tdata_i(b_tdata), .s_axis_tvalid_i(b_tvalid), .s_axis_tready_o(b_tready),
        .m_axis_tdata_o(b_mdata), .m_axis_tvalid_o(b_mvalid), .m_axis_tready_i(b_mready),
        .mem_wr_en_o(b_wr_en), .mem_wr_addr_o(b_wr_addr), .mem_wr_data_o(b_wr_data),
        .mem_rd_addr_o(b_rd_addr), .mem_rd_data_i(b_rd_data),
        .count_o(b_count), .full_o(b_full), .empty_o(b_empty)
    );

    always @(posedge clk) if (b_wr_en) mem_b[b_wr_addr] <= b_wr_data;
    assign b_rd_data = mem_b[b_rd_addr];

    // Reference model: contents as a queue, plus the expected upstream ready.
    logic [7:0] exp_q[$];
    logic       exp_ready = 1'b0;
    int         wr_total  = 0;
    int         rd_total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        logic exp_push;
        logic exp_pop;
        @(negedge clk);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        exp_push = v && exp_ready;
        exp_pop  = r && (exp_q.size() != 0);
        #1;
        check("wr_en", mem_wr_en, exp_push);
        check("wr_data", mem_wr_data, d);
        if (exp_push) check("wr_addr", mem_wr_addr, wr_total % DEPTH_A);
        if (exp_q.size() != 0) begin
            check("head", m_tdata, exp_q[0]);
            check("rd_addr", mem_rd_addr, rd_total % DEPTH_A);
        end
        @(posedge clk);
        if (exp_pop) begin
            void'(exp_q.pop_front());
            rd_total++;
        end
        if (exp_push) begin
            exp_q.push_back(d);
            wr_total++;
        end
        exp_ready = (exp_q.size() != DEPTH_A);
        #1;
        check("count", count, exp_q.size());
        check("full", full, exp_q.size() == DEPTH_A);
        check("empty", empty, exp_q.size() == 0);
        check("m_tvalid", m_tvalid, exp_q.size() != 0);
        check("s_tready", s_tready, exp_ready);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        exp_ready = 1'b0;
        wr_total = 0;
        rd_total = 0;
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_s_tready_low", s_tready, 0);
        @(posedge clk);
        exp_ready = 1'b1;
        #1;
        check("rel_s_tready_high", s_tready, 1);
        check("rel_empty", empty, 1);
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        // Fill to full with the output stalled; the 9th beat must be refused.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0);
        check("fill_full", full, 1);
        check("fill_s_tready", s_tready, 0);
        check("fill_count", count, 8);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'h09, 1'b0);
        check("bp_stable", m_tdata, 8'h01);

        // Full boundary: one pop only, then the held beat enters.
        cycle(1'b1, 8'h0A, 1'b1);
        check("fb_pop_only", count, 7);
        cycle(1'b1, 8'h0A, 1'b0);
        check("fb_refill", count, 8);

        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        check("drain_empty", empty, 1);

        // Steady push+pop at occupancy 3 with counter data.
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'(k), 1'b0);
        for (int k = 3; k < 23; k++) cycle(1'b1, 8'(k), 1'b1);
        check("steady_count", count, 3);
        check("steady_head", m_tdata, 8'd20);

        for (int n = 0; n < 300; n++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 3) != 0));

        for (int n = 0; n < 16; n++) if (exp_q.size() != 0) cycle(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        check("pre_rst_count", count, 5);
        do_reset();
        cycle(1'b1, 8'h5A, 1'b0);
        check("post_rst_head", m_tdata, 8'h5A);

        // DEPTH=5 rounds to 8 entries.
        check("d5_ready", b_tready, 1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            b_tvalid = 1'b1;
            b_tdata  = 8'(i);
            @(posedge clk);
            #1;
            check("d5_count", b_count, i);
            check("d5_full", b_full, i == 8);
        end
        @(negedge clk);
        b_tvalid = 1'b0;
        #1;
        check("d5_s_tready", b_tready, 0);
        check("d5_head", b_mdata, 8'h01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
